pipe_restart_seq: RTL and testbench

//  Sequences pipeline restarts across the NSEG DAQ pipeline segments (6 groups x 2 segments).

---
 rtl/pipe_seq_pkg.sv | 28 ++
 rtl/pipe_restart_seq_rr_arbiter.sv | 36 +++
 rtl/pipe_restart_seq.sv | 190 +++++++++++++++++++
 tb/tb_pipe_restart_seq.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_seq_pkg.sv
// Shared types, widths and the occupancy tolerance helper for the pipeline restart sequencer.
package pipe_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PULSE  = 2'd1,
    SETTLE = 2'd2,
    GAP    = 2'd3
  } seq_state_e;

  localparam int OCC_W  = 10;
  localparam int PD_W   = 9;
  localparam int SEG_W  = 4;
  localparam int CNT_W  = 16;
  localparam int ECNT_W = 8;

  // |occ - pd| <= tol, evaluated as an 11-bit signed difference.
  function automatic logic within_tol(input logic [OCC_W-1:0] occ,
                                      input logic [PD_W-1:0]  pd,
                                      input logic [OCC_W:0]   tol);
    logic signed [OCC_W:0] diff;
    logic [OCC_W:0]        mag;
    diff = $signed({1'b0, occ}) - $signed({2'b00, pd});
    mag  = diff[OCC_W] ? $unsigned(-diff) : $unsigned(diff);
    return (mag <= tol);
  endfunction

endpackage

// File: rtl/pipe_restart_seq_rr_arbiter.sv
// Combinational round-robin picker: lowest set request at or after the pointer, wrapping.
module rr_arbiter #(
  parameter int N  = 12,
  parameter int IW = 4
) (
  input  logic [N-1:0]  i_pend,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  logic [IW:0]   w_sum;
  logic [IW-1:0] w_pos;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_sum   = '0;
    w_pos   = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, i_ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(N)) begin
        w_sum = w_sum - (IW+1)'(N);
      end
      w_pos = w_sum[IW-1:0];
      if (!o_valid && i_pend[w_pos]) begin
        o_valid        = 1'b1;
        o_idx          = w_pos;
        o_grant[w_pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_restart_seq.sv
// Pipeline restart sequencer: collects restart requests, pulses one segment at a time
// round-robin, waits for refill to the programmed depth and records segments that time out.
module pipe_restart_seq
  import pipe_seq_pkg::*;
#(
  parameter int NSEG    = 12,
  parameter int PLS_LEN = 4,
  parameter int GAP_LEN = 8,
  parameter int TMO     = 1024,
  parameter int TOL     = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst_b,
  input  logic                    i_req_all,
  input  logic [NSEG-1:0]         i_req_seg,
  input  logic                    i_auto_en,
  input  logic                    i_clr_err,
  input  logic [PD_W-1:0]         i_pdepth,
  input  logic [NSEG*OCC_W-1:0]   i_occ,
  output logic [NSEG-1:0]         o_restartps,
  output logic                    o_busy,
  output logic [SEG_W-1:0]        o_cur_seg,
  output logic [NSEG-1:0]         o_err_seg,
  output logic [ECNT_W-1:0]       o_err_cnt
);

  localparam logic [OCC_W:0]     TOL_V   = (OCC_W+1)'(TOL);
  localparam logic [CNT_W-1:0]   PLS_LD  = CNT_W'(PLS_LEN - 1);
  localparam logic [CNT_W-1:0]   TMO_LD  = CNT_W'(TMO - 1);
  localparam logic [CNT_W-1:0]   GAP_LD  = CNT_W'(GAP_LEN - 1);
  localparam logic [SEG_W-1:0]   SEG_MAX = SEG_W'(NSEG - 1);

  seq_state_e          r_state, w_state_next;
  logic [NSEG-1:0]     r_pend, w_pend_next;
  logic [SEG_W-1:0]    r_rr_ptr, w_rr_next;
  logic [SEG_W-1:0]    r_cur_seg, w_cur_next;
  logic [SEG_W-1:0]    r_scan_ptr, w_scan_next;
  logic [CNT_W-1:0]    r_cnt, w_cnt_next;
  logic [PD_W-1:0]     r_pd_lat;
  logic [NSEG-1:0]     r_restartps;
  logic [NSEG-1:0]     r_err_seg, w_err_seg_next;
  logic [ECNT_W-1:0]   r_err_cnt, w_err_cnt_next;

  logic [OCC_W-1:0]    w_occ_arr [NSEG];
  logic [NSEG-1:0]     w_cur_onehot;
  logic [NSEG-1:0]     w_scan_onehot;
  logic [NSEG-1:0]     w_grant;
  logic [NSEG-1:0]     w_auto_hit;
  logic [SEG_W-1:0]    w_grant_idx;
  logic                w_grant_vld;
  logic                w_grant_take;
  logic                w_settled;
  logic                w_scan_healthy;
  logic                w_mon_active;
  logic                w_timeout;

  genvar gi;
  generate
    for (gi = 0; gi < NSEG; gi++) begin : g_seg
      assign w_occ_arr[gi]     = i_occ[gi*OCC_W +: OCC_W];
      assign w_cur_onehot[gi]  = (r_cur_seg  == SEG_W'(gi));
      assign w_scan_onehot[gi] = (r_scan_ptr == SEG_W'(gi));
    end
  endgenerate

  rr_arbiter #(
    .N  (NSEG),
    .IW (SEG_W)
  ) u_arb (
    .i_pend  (r_pend),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_grant_idx),
    .o_valid (w_grant_vld)
  );

  // Settling compares against the depth captured at grant time; the monitor uses the live depth.
  assign w_settled      = within_tol(w_occ_arr[r_cur_seg],  r_pd_lat, TOL_V);
  assign w_scan_healthy = within_tol(w_occ_arr[r_scan_ptr], i_pdepth, TOL_V);
  assign w_mon_active   = i_auto_en && (r_state == IDLE) && (r_pend == '0);
  assign w_auto_hit     = (w_mon_active && !w_scan_healthy) ? w_scan_onehot : '0;
  assign w_scan_next    = !w_mon_active         ? r_scan_ptr :
                          (r_scan_ptr == SEG_MAX) ? '0 : r_scan_ptr + SEG_W'(1);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_cur_next   = r_cur_seg;
    w_rr_next    = r_rr_ptr;
    w_grant_take = 1'b0;
    w_timeout    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_grant_vld) begin
          w_grant_take = 1'b1;
          w_cur_next   = w_grant_idx;
          w_rr_next    = (w_grant_idx == SEG_MAX) ? '0 : w_grant_idx + SEG_W'(1);
          w_cnt_next   = PLS_LD;
          w_state_next = PULSE;
        end
      end
      PULSE: begin
        if (r_cnt == '0) begin
          w_cnt_next   = TMO_LD;
          w_state_next = SETTLE;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      SETTLE: begin
        if (w_settled) begin
          w_cnt_next   = GAP_LD;
          w_state_next = GAP;
        end else if (r_cnt == '0) begin
          w_timeout    = 1'b1;
          w_cnt_next   = GAP_LD;
          w_state_next = GAP;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      GAP: begin
        if (r_cnt == '0) begin
          w_state_next = IDLE;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Clearing the granted bit first lets a same-cycle request for that segment re-arm it.
  assign w_pend_next = (r_pend & ~(w_grant_take ? w_grant : '0))
                     | i_req_seg | {NSEG{i_req_all}} | w_auto_hit;

  always_comb begin
    w_err_seg_next = r_err_seg;
    w_err_cnt_next = r_err_cnt;
    if (w_timeout) begin
      if (i_clr_err) begin
        w_err_seg_next = w_cur_onehot;
        w_err_cnt_next = ECNT_W'(1);
      end else begin
        w_err_seg_next = r_err_seg | w_cur_onehot;
        if (r_err_cnt != '1) begin
          w_err_cnt_next = r_err_cnt + ECNT_W'(1);
        end
      end
    end else if (i_clr_err) begin
      w_err_seg_next = '0;
      w_err_cnt_next = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      r_state     <= IDLE;
      r_pend      <= '0;
      r_rr_ptr    <= '0;
      r_cur_seg   <= '0;
      r_scan_ptr  <= '0;
      r_cnt       <= '0;
      r_pd_lat    <= '0;
      r_restartps <= '0;
      r_err_seg   <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_state     <= w_state_next;
      r_pend      <= w_pend_next;
      r_rr_ptr    <= w_rr_next;
      r_cur_seg   <= w_cur_next;
      r_scan_ptr  <= w_scan_next;
      r_cnt       <= w_cnt_next;
      r_restartps <= (r_state == PULSE) ? w_cur_onehot : '0;
      r_err_seg   <= w_err_seg_next;
      r_err_cnt   <= w_err_cnt_next;
      if ((r_state == PULSE) && (r_cnt == PLS_LD)) begin
        r_pd_lat <= i_pdepth;
      end
    end
  end

  assign o_restartps = r_restartps;
  assign o_busy      = (r_state != IDLE) || (r_pend != '0);
  assign o_cur_seg   = r_cur_seg;
  assign o_err_seg   = r_err_seg;
  assign o_err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_pipe_restart_seq.sv
// Directed bench for pipe_restart_seq: main instance with default timing, plus a short-timeout
// instance used to drive the error counter into saturation quickly.
module tb_pipe_restart_seq;
  import pipe_seq_pkg::*;

  localparam int NSEG = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n;
  logic                  req_all;
  logic [NSEG-1:0]       req_seg;
  logic                  auto_en;
  logic                  clr_err;
  logic [PD_W-1:0]       pdepth;
  logic [NSEG*OCC_W-1:0] occ;
  logic [NSEG-1:0]       rp;
  logic                  busy;
  logic [SEG_W-1:0]      cur;
  logic [NSEG-1:0]       err_seg;
  logic [ECNT_W-1:0]     err_cnt;

  logic                  s_req_all;
  logic [NSEG-1:0]       s_req_seg;
  logic                  s_auto_en;
  logic                  s_clr_err;
  logic [PD_W-1:0]       s_pdepth;
  logic [NSEG*OCC_W-1:0] s_occ;
  logic [NSEG-1:0]       s_rp;
  logic                  s_busy;
  logic [SEG_W-1:0]      s_cur;
  logic [NSEG-1:0]       s_err_seg;
  logic [ECNT_W-1:0]     s_err_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  pipe_restart_seq u_dut (
    .i_clk(clk), .i_rst_b(rst_n), .i_req_all(req_all), .i_req_seg(req_seg),
    .i_auto_en(auto_en), .i_clr_err(clr_err), .i_pdepth(pdepth), .i_occ(occ),
    .o_restartps(rp), .o_busy(busy), .o_cur_seg(cur), .o_err_seg(err_seg), .o_err_cnt(err_cnt)
  );

  pipe_restart_seq #(.TMO(8)) u_sat (
    .i_clk(clk), .i_rst_b(rst_n), .i_req_all(s_req_all), .i_req_seg(s_req_seg),
    .i_auto_en(s_auto_en), .i_clr_err(s_clr_err), .i_pdepth(s_pdepth), .i_occ(s_occ),
    .o_restartps(s_rp), .o_busy(s_busy), .o_cur_seg(s_cur), .o_err_seg(s_err_seg), .o_err_cnt(s_err_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_occ(input int seg, input int val);
    occ[seg*OCC_W +: OCC_W] = OCC_W'(val);
  endtask

  task automatic set_all(input int val);
    for (int s = 0; s < NSEG; s++) occ[s*OCC_W +: OCC_W] = OCC_W'(val);
  endtask

  task automatic wait_rp(input logic [NSEG-1:0] val, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (rp === val) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    bit              ok;
    int              n_bad;
    int              n_multi;
    int              n_high;
    int              idx;
    int              exp_cnt;
    int              seq_q[$];
    logic [NSEG-1:0] prev;

    rst_n     = 1'b0;
    req_all   = 1'b0;
    req_seg   = '0;
    auto_en   = 1'b0;
    clr_err   = 1'b0;
    pdepth    = 9'd100;
    occ       = '0;
    set_all(100);
    s_req_all = 1'b0;
    s_req_seg = '0;
    s_auto_en = 1'b0;
    s_clr_err = 1'b0;
    s_pdepth  = 9'd100;
    s_occ     = '0;

    // Reset state
    #2;
    check("rst_restartps", 32'(rp), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_cur_seg", 32'(cur), 32'h0);
    check("rst_err_seg", 32'(err_seg), 32'h0);
    check("rst_err_cnt", 32'(err_cnt), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_idle_busy", 32'(busy), 32'h0);

    // REQ_ALL with all segments healthy: 0..11 in order, one pulse at a time
    req_all = 1'b1;
    tick();
    req_all = 1'b0;
    n_multi = 0;
    n_high  = 0;
    prev    = '0;
    ok      = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($countones(rp) > 1) n_multi++;
      if (rp != '0) n_high++;
      if (rp != '0 && prev == '0) begin
        idx = -1;
        for (int b = 0; b < NSEG; b++) if (rp[b]) idx = b;
        seq_q.push_back(idx);
      end
      prev = rp;
      if (!busy && i > 0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("all_done", 32'(ok), 32'h1);
    check("all_count", 32'(seq_q.size()), 32'd12);
    for (int i = 0; i < seq_q.size(); i++) check($sformatf("all_order_%0d", i), 32'(seq_q[i]), 32'(i));
    check("all_onehot", 32'(n_multi), 32'h0);
    check("all_width", 32'(n_high), 32'd48);
    check("all_err", 32'(err_seg), 32'h0);

    // Single request on seg 5, refill after a while
    set_occ(5, 0);
    req_seg = 12'h020;
    tick();
    req_seg = '0;
    check("s5_busy_pend", 32'(busy), 32'h1);
    check("s5_rp_p1", 32'(rp), 32'h0);
    tick();
    check("s5_cur", 32'(cur), 32'd5);
    check("s5_rp_p2", 32'(rp), 32'h0);
    tick();
    check("s5_rp_rise", 32'(rp), 32'h020);
    repeat (3) tick();
    check("s5_rp_last", 32'(rp), 32'h020);
    tick();
    check("s5_rp_fall", 32'(rp), 32'h0);
    repeat (30) tick();
    check("s5_settling_busy", 32'(busy), 32'h1);
    set_occ(5, 100);
    tick();
    repeat (7) tick();
    check("s5_gap_busy", 32'(busy), 32'h1);
    tick();
    check("s5_idle", 32'(busy), 32'h0);
    check("s5_err", 32'(err_seg), 32'h0);

    // Seg 3 stuck at 0 times out after 1024 settle cycles; seg 4 is serviced next
    set_occ(3, 0);
    req_seg = 12'h018;
    tick();
    req_seg = '0;
    tick();
    check("t3_cur", 32'(cur), 32'd3);
    repeat (1027) tick();
    check("t3_pre_tmo_err", 32'(err_seg), 32'h0);
    tick();
    check("t3_err_seg", 32'(err_seg), 32'h008);
    check("t3_err_cnt", 32'(err_cnt), 32'd1);
    wait_rp(12'h010, 40, ok);
    check("t3_next_seg4", 32'(ok), 32'h1);
    wait_idle(60, ok);
    check("t3_idle", 32'(ok), 32'h1);
    check("t3_err_keep", 32'(err_seg), 32'h008);
    set_occ(3, 100);

    // Occupancy monitor
    pdepth = 9'd200;
    set_all(200);
    set_occ(7, 190);
    tick();
    auto_en = 1'b1;
    wait_rp(12'h080, 40, ok);
    check("auto_s7_restart", 32'(ok), 32'h1);
    check("auto_s7_cur", 32'(cur), 32'd7);
    set_occ(7, 200);
    wait_idle(60, ok);
    check("auto_s7_idle", 32'(ok), 32'h1);
    check("auto_err_cnt", 32'(err_cnt), 32'd1);
    set_occ(7, 199);
    n_bad = 0;
    repeat (40) begin
      tick();
      if (rp != '0 || busy) n_bad++;
    end
    check("auto_within_tol", 32'(n_bad), 32'h0);
    set_occ(7, 203);
    wait_rp(12'h080, 40, ok);
    check("auto_tol_plus1", 32'(ok), 32'h1);
    set_occ(7, 200);
    wait_idle(60, ok);
    check("auto_tol_idle", 32'(ok), 32'h1);
    auto_en = 1'b0;
    tick();

    // CLR_ERR in the same cycle as a timeout on seg 2
    set_occ(2, 0);
    req_seg = 12'h004;
    tick();
    req_seg = '0;
    repeat (1028) tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("clr_tmo_err_seg", 32'(err_seg), 32'h004);
    check("clr_tmo_err_cnt", 32'(err_cnt), 32'd1);
    wait_idle(30, ok);
    check("clr_idle", 32'(ok), 32'h1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("clr_err_seg", 32'(err_seg), 32'h0);
    check("clr_err_cnt", 32'(err_cnt), 32'h0);
    set_occ(2, 200);

    // Saturation of ERR_CNT using the short-timeout instance: 25 rounds x 12 timeouts
    for (int r = 1; r <= 25; r++) begin
      s_req_all = 1'b1;
      tick();
      s_req_all = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 600; i++) begin
        if (s_busy === 1'b0) begin
          ok = 1'b1;
          break;
        end
        tick();
      end
      check($sformatf("sat_done_%0d", r), 32'(ok), 32'h1);
      exp_cnt = (12 * r > 255) ? 255 : 12 * r;
      check($sformatf("sat_cnt_%0d", r), 32'(s_err_cnt), 32'(exp_cnt));
    end
    check("sat_err_seg", 32'(s_err_seg), 32'hFFF);

    // Asynchronous reset in the middle of a pulse
    req_seg = 12'h001;
    tick();
    req_seg = '0;
    wait_rp(12'h001, 10, ok);
    check("arst_pulse_seen", 32'(ok), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_rp", 32'(rp), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_cur", 32'(cur), 32'h0);
    check("arst_sat_err_cnt", 32'(s_err_cnt), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    n_bad = 0;
    repeat (20) begin
      tick();
      if (rp != '0 || busy) n_bad++;
    end
    check("arst_no_pulse", 32'(n_bad), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
